// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath constants and the writeback request type used by
// the register-file write-port arbiter and its bench.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_X0 = '0;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage : rv32i_pkg

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: searches from i_ptr upward (mod N) and
// grants the first asserted request, giving a one-hot grant and its index.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin : g_search
      int j;
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = ($clog2(N))'(j);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among N_REQ writeback
// requesters (round-robin) and tracks reserved destinations for decode stalls.
module regfile_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int AW    = rv32i_pkg::AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*AW-1:0]   req_addr,
  input  logic [N_REQ*XLEN-1:0] req_data,
  output logic                  rf_write,
  output logic [AW-1:0]         rf_wa,
  output logic [XLEN-1:0]       rf_wd,
  input  logic                  rsv_valid,
  input  logic [AW-1:0]         rsv_addr,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic                  busy1,
  output logic                  busy2
);

  localparam int PW   = $clog2(N_REQ);
  localparam int NREG = 2 ** AW;
  localparam logic [AW-1:0] X0 = AW'(REG_X0);

  logic [PW-1:0]    r_ptr;
  logic [N_REQ-1:0] w_grant;
  logic [PW-1:0]    w_gidx;
  logic             w_xfer;
  logic [AW-1:0]    w_addr;
  logic [XLEN-1:0]  w_data;

  logic             r_rf_write;
  logic [AW-1:0]    r_rf_wa;
  logic [XLEN-1:0]  r_rf_wd;

  logic [NREG-1:0]  r_pending;
  logic [NREG-1:0]  w_pending_nxt;

  // Grant depends only on req_valid and the pointer, so ready never loops back.
  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_xfer)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr = req_addr[i*AW +: AW];
        w_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Clear on acceptance first, then apply the reservation so a younger
  // reservation to the same register survives.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_xfer && (w_addr != X0)) w_pending_nxt[w_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != X0)) w_pending_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_rf_write <= 1'b0;
      r_rf_wa    <= '0;
      r_rf_wd    <= '0;
      // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared by reset
      // like any other state; stale pending bits would otherwise stall decode forever.
      r_pending  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (w_xfer) begin
        r_ptr      <= (int'(w_gidx) == N_REQ - 1) ? '0 : w_gidx + 1'b1;
        r_rf_write <= (w_addr != X0);
        r_rf_wa    <= w_addr;
        r_rf_wd    <= w_data;
      end else begin
        r_rf_write <= 1'b0;
      end
      r_pending <= w_pending_nxt;
    end
  end

  assign rf_write = r_rf_write;
  assign rf_wa    = r_rf_wa;
  assign rf_wd    = r_rf_wd;

  assign busy1 = (ra1 != X0) && r_pending[ra1];
  assign busy2 = (ra2 != X0) && r_pending[ra2];

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (N_REQ=2): reset,
// contention, x0, scoreboard timing, set/clear race, idle and mid-run reset.
module tb_regfile_wb_arbiter;
  import rv32i_pkg::*;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*XLEN-1:0] req_data;
  logic              rf_write;
  logic [AW-1:0]     rf_wa;
  logic [XLEN-1:0]   rf_wd;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic [AW-1:0]     ra1;
  logic [AW-1:0]     ra2;
  logic              busy1;
  logic              busy2;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_write  (rf_write),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .ra1       (ra1),
    .ra2       (ra2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int i, input wb_req_t r);
    req_valid[i]             = r.valid;
    req_addr[i*AW +: AW]     = r.addr;
    req_data[i*XLEN +: XLEN] = r.data;
  endtask

  task automatic idle_reqs();
    req_valid = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    ra1       = '0;
    ra2       = '0;

    // Reset state
    settle();
    check("rst_rf_write", {31'd0, rf_write}, 32'd0);
    check("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_ready", {30'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;

    // Contention: alternating grants, each write one cycle after its grant
    drive_req(0, '{valid: 1'b1, addr: 5'd3, data: 32'h11});
    drive_req(1, '{valid: 1'b1, addr: 5'd4, data: 32'h22});
    settle();
    check("cont_ready0", {30'd0, req_ready}, 32'b01);
    tick(); settle();
    check("cont_ready1", {30'd0, req_ready}, 32'b10);
    check("cont_w0_we", {31'd0, rf_write}, 32'd1);
    check("cont_w0_wa", {27'd0, rf_wa}, 32'd3);
    check("cont_w0_wd", rf_wd, 32'h11);
    tick(); settle();
    check("cont_ready2", {30'd0, req_ready}, 32'b01);
    check("cont_w1_wa", {27'd0, rf_wa}, 32'd4);
    check("cont_w1_wd", rf_wd, 32'h22);
    tick(); settle();
    check("cont_ready3", {30'd0, req_ready}, 32'b10);
    check("cont_w2_wa", {27'd0, rf_wa}, 32'd3);
    tick();
    idle_reqs();
    settle();
    check("cont_w3_we", {31'd0, rf_write}, 32'd1);
    check("cont_w3_wa", {27'd0, rf_wa}, 32'd4);
    check("cont_w3_wd", rf_wd, 32'h22);
    check("cont_idle_ready", {30'd0, req_ready}, 32'd0);
    tick(); settle();
    check("cont_after_we", {31'd0, rf_write}, 32'd0);
    check("cont_hold_wa", {27'd0, rf_wa}, 32'd4);
    check("cont_hold_wd", rf_wd, 32'h22);

    // x0: accepted but never written; reservation of x0 ignored
    tick();
    drive_req(1, '{valid: 1'b1, addr: 5'd0, data: 32'hDEAD});
    rsv_valid = 1'b1;
    rsv_addr  = 5'd0;
    ra1       = 5'd0;
    settle();
    check("x0_ready", {30'd0, req_ready}, 32'b10);
    tick();
    idle_reqs();
    settle();
    check("x0_no_write", {31'd0, rf_write}, 32'd0);
    check("x0_busy1", {31'd0, busy1}, 32'd0);

    // Scoreboard timing on x7
    tick();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd7;
    ra2       = 5'd7;
    settle();
    check("sb_c0_busy2", {31'd0, busy2}, 32'd0);
    tick();
    rsv_valid = 1'b0;
    settle();
    check("sb_c1_busy2", {31'd0, busy2}, 32'd1);
    tick(); settle();
    check("sb_c2_busy2", {31'd0, busy2}, 32'd1);
    tick();
    drive_req(0, '{valid: 1'b1, addr: 5'd7, data: 32'h77});
    settle();
    check("sb_c3_ready", {30'd0, req_ready}, 32'b01);
    check("sb_c3_busy2", {31'd0, busy2}, 32'd1);
    tick();
    idle_reqs();
    settle();
    check("sb_c4_busy2", {31'd0, busy2}, 32'd0);
    check("sb_c4_we", {31'd0, rf_write}, 32'd1);
    check("sb_c4_wa", {27'd0, rf_wa}, 32'd7);
    check("sb_c4_wd", rf_wd, 32'h77);

    // Set/clear race on x9: set wins, write still happens (pointer now 1)
    tick();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    ra1       = 5'd9;
    tick();
    drive_req(0, '{valid: 1'b1, addr: 5'd9, data: 32'h99});
    settle();
    check("race_ready", {30'd0, req_ready}, 32'b01);
    check("race_busy_pre", {31'd0, busy1}, 32'd1);
    tick();
    idle_reqs();
    settle();
    check("race_busy_post", {31'd0, busy1}, 32'd1);
    check("race_we", {31'd0, rf_write}, 32'd1);
    check("race_wa", {27'd0, rf_wa}, 32'd9);
    check("race_wd", rf_wd, 32'h99);
    tick();
    drive_req(0, '{valid: 1'b1, addr: 5'd9, data: 32'h9A});
    tick();
    idle_reqs();
    settle();
    check("race_cleared", {31'd0, busy1}, 32'd0);

    // Idle 10 cycles; pointer stays at 1 so req1 wins a tie afterwards
    for (int c = 0; c < 10; c++) begin
      tick(); settle();
      check("idle_ready", {30'd0, req_ready}, 32'd0);
      check("idle_we", {31'd0, rf_write}, 32'd0);
    end
    tick();
    drive_req(0, '{valid: 1'b1, addr: 5'd10, data: 32'hA0});
    drive_req(1, '{valid: 1'b1, addr: 5'd11, data: 32'hB1});
    settle();
    check("idle_ptr_hold", {30'd0, req_ready}, 32'b10);
    tick(); settle();
    check("idle_next_ready", {30'd0, req_ready}, 32'b01);
    check("idle_next_wa", {27'd0, rf_wa}, 32'd11);
    tick();
    idle_reqs();

    // Mid-run async reset drops pending bits and an in-flight write
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    ra1       = 5'd5;
    tick();
    rsv_valid = 1'b0;
    drive_req(0, '{valid: 1'b1, addr: 5'd6, data: 32'h66});
    settle();
    check("mrst_busy_pre", {31'd0, busy1}, 32'd1);
    tick();
    idle_reqs();
    check("mrst_we_pre", {31'd0, rf_write}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mrst_we", {31'd0, rf_write}, 32'd0);
    check("mrst_busy1", {31'd0, busy1}, 32'd0);
    tick();
    rst = 1'b0;
    drive_req(0, '{valid: 1'b1, addr: 5'd12, data: 32'hC0});
    drive_req(1, '{valid: 1'b1, addr: 5'd13, data: 32'hD1});
    settle();
    check("mrst_first_grant", {30'd0, req_ready}, 32'b01);
    tick();
    idle_reqs();
    settle();
    check("mrst_first_wa", {27'd0, rf_wa}, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
